// File: rtl/image_stream_feeder_pkg.sv
// Shared definitions for the image streaming path (feeder and processors).
//   COLOR_SIZE      : bits per pixel. It is also available as the `COLOR_SIZE macro
//                     so that port declarations can use it.
//   feeder_state_t  : states of the image_stream_feeder FSM.
//   proc_mode_t     : processor mode encoding, shared with the threshold and
//                     brightness processors.
`ifndef COLOR_SIZE
`define COLOR_SIZE 8
`endif

package image_stream_feeder_pkg;

  localparam int COLOR_SIZE = `COLOR_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  typedef enum logic [1:0] {
    MODE_THRESHOLD  = 2'd0,
    MODE_BRIGHT_ADD = 2'd1,
    MODE_BRIGHT_SUB = 2'd2
  } proc_mode_t;

endpackage

// File: rtl/pixel_word_packer.sv
// Packs a stream of pixels into DATA_WIDTH words; lane i = bits [i*COLOR_SIZE +: COLOR_SIZE].
// The returned pixel is inserted combinationally, so the caller can register
// the completed word on the same edge that the final lane arrives.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : clear the lane register and the lane counter
//   pix_vld    : pix holds the next pixel in this cycle
//   pix        : pixel data
//   flush      : the current pixel is the last pixel of the image, so close the word
//   word       : the word with pix placed in the current lane (valid when word_vld = 1)
//   word_vld   : a word is complete in this cycle
// Macro FEEDER_PAD_REPLICATE_EN: when it is defined, the unused lanes of a flushed word
// repeat the last pixel. When it is undefined, those lanes are zero.
module pixel_word_packer
  import image_stream_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  pix_vld,
  input  logic [COLOR_SIZE-1:0] pix,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_vld
);

  localparam int PIX_PER_WORD = DATA_WIDTH / COLOR_SIZE;
  localparam int LANE_W       = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);

  logic [DATA_WIDTH-1:0] lanes_q, lanes_d;
  logic [LANE_W-1:0]     lane_q, lane_d;

  assign word_vld = pix_vld && ((lane_q == LAST_LANE) || flush);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    word = lanes_q;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (LANE_W'(i) == lane_q) begin
        word[i*COLOR_SIZE +: COLOR_SIZE] = pix;
      end
`ifdef FEEDER_PAD_REPLICATE_EN
      else if (flush && (LANE_W'(i) > lane_q)) begin
        word[i*COLOR_SIZE +: COLOR_SIZE] = pix;
      end
`endif
    end
  end

  // Lanes are cleared after each word. In the default build, this clearing
  // is what makes the unused lanes of a partial word zero.
  always_comb begin
    lanes_d = lanes_q;
    lane_d  = lane_q;
    if (clr || word_vld) begin
      lanes_d = '0;
      lane_d  = '0;
    end else if (pix_vld) begin
      lanes_d = word;
      lane_d  = lane_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q <= '0;
      lane_q  <= '0;
    end else begin
      lanes_q <= lanes_d;
      lane_q  <= lane_d;
    end
  end

endmodule

// File: rtl/image_stream_feeder.sv
// Source side of the pixel stream (vld / last_data / data_out). The block reads
// num_pixels bytes from image memory, starting at base_addr. The address wraps at
// 2^ADDR_WIDTH. It packs PIX_PER_WORD pixels into each word, marks the final word
// with last_data, and pulses done one cycle later. All outputs are registered.
// Ports:
//   clk, rst_n            : clock and asynchronous active-low reset
//   start                 : begin a transfer. It is sampled only in IDLE.
//   base_addr, num_pixels : transfer setup, latched on start. num_pixels = 0 is legal.
//   mem_rd_en, mem_addr   : memory read strobe and address
//   mem_rd_data           : read data, valid the cycle after mem_rd_en
//   vld, last_data        : word strobe, and the marker for the final word
//   data_out              : packed word. It is 0 whenever vld is low.
//   busy, done            : busy is high in READ/FLUSH. done is a one-cycle completion pulse.
// Macro FEEDER_PAD_REPLICATE_EN (in pixel_word_packer) selects how the partial
// final word is padded.
module image_stream_feeder
  import image_stream_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [ADDR_WIDTH-1:0]  num_pixels,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [`COLOR_SIZE-1:0] mem_rd_data,
  output logic                   vld,
  output logic                   last_data,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   busy,
  output logic                   done
);

  feeder_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] num_q, num_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;       // index of the read being issued
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic                  rd_pend_q;                 // read data returns in this cycle
  logic                  rd_last_q;                 // the returning pixel is the final pixel
  logic                  vld_q, last_q, busy_q, done_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  final_rd;
  logic                  pk_clr, pk_word_vld;
  logic [DATA_WIDTH-1:0] pk_word;

  assign final_rd = (state_q == READ) && (rd_cnt_q == num_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    rd_cnt_d    = rd_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_en_d = 1'b0;
    pk_clr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_pixels == '0) begin
            state_d = DONE;
          end else begin
            state_d     = READ;
            num_d       = num_pixels;
            rd_cnt_d    = '0;
            mem_addr_d  = base_addr;
            mem_rd_en_d = 1'b1;
            pk_clr      = 1'b1;
          end
        end
      end
      READ: begin
        if (final_rd) begin
          state_d = FLUSH;
        end else begin
          rd_cnt_d    = rd_cnt_q + 1'b1;
          mem_addr_d  = mem_addr_q + 1'b1;  // wraps modulo 2^ADDR_WIDTH
          mem_rd_en_d = 1'b1;
        end
      end
      // last_q is high in the cycle the final word is presented, so done follows it.
      FLUSH:   if (last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  pixel_word_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pk_clr),
    .pix_vld  (rd_pend_q),
    .pix      (mem_rd_data),
    .flush    (rd_last_q),
    .word     (pk_word),
    .word_vld (pk_word_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_q       <= '0;
      rd_cnt_q    <= '0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_last_q   <= 1'b0;
      vld_q       <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      rd_cnt_q    <= rd_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
      rd_pend_q   <= mem_rd_en_q;
      rd_last_q   <= final_rd;
      vld_q       <= pk_word_vld;
      last_q      <= pk_word_vld && rd_last_q;
      data_q      <= pk_word_vld ? pk_word : '0;
      busy_q      <= (state_d == READ) || (state_d == FLUSH);
      done_q      <= (state_d == DONE);
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign vld       = vld_q;
  assign last_data = last_q;
  assign data_out  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_image_stream_feeder.sv
// Directed testbench for image_stream_feeder (DATA_WIDTH 32, 4 pixels per word).
// Cycle c is sampled on the falling edge after rising edge c-1. Rising edge 0
// is the edge that samples start.
module tb_image_stream_feeder;
  import image_stream_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] num_pixels = '0;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data = '0;
  logic        vld, last_data, busy, done;
  logic [31:0] data_out;

  logic [7:0]  mem [0:65535];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] addr_log [$];
  logic [31:0] word_log [$];
  logic        last_log [$];
  int          vld_cyc  [$];
  int          done_cyc, done_cnt, data_nz, busy_c1;

  image_stream_feeder #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .num_pixels  (num_pixels),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .vld         (vld),
    .last_data   (last_data),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Byte memory with a one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one transfer and logs what it sees. rep_cyc > 0 re-pulses start with a
  // different setup in that cycle. rst_cyc > 0 asserts rst_n in that cycle and
  // checks that all outputs clear at once.
  task automatic run_xfer(input logic [15:0] base, input logic [15:0] n,
                          input int rep_cyc, input int rst_cyc);
    int c;
    addr_log.delete(); word_log.delete(); last_log.delete(); vld_cyc.delete();
    done_cyc = -1; done_cnt = 0; data_nz = 0; busy_c1 = 0;
    @(negedge clk);
    start = 1'b1; base_addr = base; num_pixels = n;
    c = 0;
    while (c < 60) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (c == rep_cyc) begin
        start = 1'b1; base_addr = 16'h0040; num_pixels = 16'd2;
      end
      if (c == 1) busy_c1 = int'(busy);
      if (mem_rd_en) addr_log.push_back(mem_addr);
      if (vld) begin
        vld_cyc.push_back(c); word_log.push_back(data_out); last_log.push_back(last_data);
      end else if (data_out != '0) begin
        data_nz++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs", {mem_rd_en, mem_addr, vld, last_data, data_out, busy, done}, '0);
        break;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0;
    if (rst_cyc == 0) check("done_seen_before_timeout", 64'(done_cyc >= 0), 64'd1);
  endtask

  initial begin
    logic [31:0] exp_partial;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[16'h0010 + i] = 8'(i + 1);
    mem[16'hFFFE] = 8'hA1; mem[16'hFFFF] = 8'hB2; mem[16'h0000] = 8'hC3; mem[16'h0001] = 8'hD4;

    repeat (2) @(negedge clk);
    check("reset_outputs", {mem_rd_en, mem_addr, vld, last_data, data_out, busy, done}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // N=8 from 0x0010: two full words.
    run_xfer(16'h0010, 16'd8, 0, 0);
    check("n8_busy_c1", 64'(busy_c1), 64'd1);
    check("n8_rd_count", 64'(addr_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) check($sformatf("n8_addr%0d", i), 64'(addr_log[i]), 64'(16'h0010 + i));
    check("n8_vld_count", 64'(vld_cyc.size()), 64'd2);
    check("n8_vld0_cycle", 64'(vld_cyc[0]), 64'd6);
    check("n8_vld1_cycle", 64'(vld_cyc[1]), 64'd10);
    check("n8_word0", 64'(word_log[0]), 64'h04030201);
    check("n8_last0", 64'(last_log[0]), 64'd0);
    check("n8_word1", 64'(word_log[1]), 64'h08070605);
    check("n8_last1", 64'(last_log[1]), 64'd1);
    check("n8_done_cycle", 64'(done_cyc), 64'd11);
    check("n8_done_count", 64'(done_cnt), 64'd1);
    check("n8_data_zero_idle", 64'(data_nz), 64'd0);

    // N=6: partial final word.
`ifdef FEEDER_PAD_REPLICATE_EN
    exp_partial = 32'h06060605;
`else
    exp_partial = 32'h00000605;
`endif
    run_xfer(16'h0010, 16'd6, 0, 0);
    check("n6_vld_count", 64'(vld_cyc.size()), 64'd2);
    check("n6_word0", 64'(word_log[0]), 64'h04030201);
    check("n6_word1", 64'(word_log[1]), 64'(exp_partial));
    check("n6_last1", 64'(last_log[1]), 64'd1);
    check("n6_vld1_cycle", 64'(vld_cyc[1]), 64'd8);
    check("n6_done_cycle", 64'(done_cyc), 64'd9);

    // N=0: only the done pulse.
    run_xfer(16'h0010, 16'd0, 0, 0);
    check("n0_rd_count", 64'(addr_log.size()), 64'd0);
    check("n0_vld_count", 64'(vld_cyc.size()), 64'd0);
    check("n0_done_cycle", 64'(done_cyc), 64'd1);
    check("n0_done_count", 64'(done_cnt), 64'd1);

    // The address wraps from 0xFFFE.
    run_xfer(16'hFFFE, 16'd4, 0, 0);
    check("wrap_rd_count", 64'(addr_log.size()), 64'd4);
    check("wrap_addr0", 64'(addr_log[0]), 64'hFFFE);
    check("wrap_addr1", 64'(addr_log[1]), 64'hFFFF);
    check("wrap_addr2", 64'(addr_log[2]), 64'h0000);
    check("wrap_addr3", 64'(addr_log[3]), 64'h0001);
    check("wrap_vld_count", 64'(vld_cyc.size()), 64'd1);
    check("wrap_word", 64'(word_log[0]), 64'hD4C3B2A1);
    check("wrap_last", 64'(last_log[0]), 64'd1);
    check("wrap_done_cycle", 64'(done_cyc), 64'd7);

    // A start during READ, with a new base and count, is ignored.
    run_xfer(16'h0010, 16'd8, 3, 0);
    check("rep_rd_count", 64'(addr_log.size()), 64'd8);
    check("rep_addr7", 64'(addr_log[7]), 64'h0017);
    check("rep_word0", 64'(word_log[0]), 64'h04030201);
    check("rep_word1", 64'(word_log[1]), 64'h08070605);
    check("rep_done_cycle", 64'(done_cyc), 64'd11);
    check("rep_done_count", 64'(done_cnt), 64'd1);

    // A reset in cycle 4 aborts the transfer. After release, no stray done or vld appears.
    run_xfer(16'h0010, 16'd8, 0, 4);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0; data_nz = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (vld) data_nz++;
    end
    check("rst_no_done", 64'(done_cnt), 64'd0);
    check("rst_no_vld", 64'(data_nz), 64'd0);
    run_xfer(16'h0010, 16'd8, 0, 0);
    check("rst_new_word0", 64'(word_log[0]), 64'h04030201);
    check("rst_new_vld0_cycle", 64'(vld_cyc[0]), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
